tile_collision_mover: RTL
=========================

Name: tile_collision_mover

Overview:
- Consumes the 30x40 wall bitmap produced by the tile ROM and owns the player's pixel position on the 640x480 playfield.
- Once per frame tick it takes a direction request and computes a candidate position.
- It checks the four corners of the player's bounding box against the bitmap, then commits or rejects the move.
- Its outputs feed the sprite/colour mapper downstream.

Parameters:
- TILE_SHIFT, 4, log2 of tile edge in pixels (16 px tiles; 40x30 tiles = 640x480).
- SIZE, 16, player square edge in pixels; must be 1..2^TILE_SHIFT.
- STEP, 2, pixels moved per accepted tick; must be 1..15.
- START_X, 16, reset x position (pixels, top-left of box).
- START_Y, 16, reset y position (pixels, top-left of box).

Ports:
- Clk, input, 1, system clock; all state is on its rising edge.
- Reset, input, 1, asynchronous, active-high; forces reset state immediately.
- frame_tick, input, 1, single-cycle pulse, once per frame.
- dir, input, 4, move request: [3]=up, [2]=down, [1]=left, [0]=right.
- Tile, input, [0:29][0:39], wall map from the ROM. Tile[r][c]=1 means wall; r is row (0=top) and c is column (0=leftmost, MSB of the row word).
- pos_x, output, 10, player x (top-left), registered.
- pos_y, output, 10, player y (top-left), registered.
- busy, output, 1, high while a move evaluation is in progress.
- move_done, output, 1, one-cycle pulse when an evaluation completes.
- blocked, output, 1, one-cycle pulse coincident with move_done when the move was rejected.

Behaviour:
- Reset values: pos_x=START_X, pos_y=START_Y, busy=0, move_done=0, blocked=0, FSM=IDLE, internal hit flag cleared.
- FSM states:
  - IDLE.
  - CALC.
  - CHK (2-bit corner counter k=0..3).
  - DONE.
- IDLE:
  - On frame_tick=1 with dir!=0: latch dir with priority up>down>left>right (only the highest set bit is used), go to CALC, and busy=1 from the next cycle.
  - frame_tick with dir=0: stay in IDLE, no pulses.
- CALC:
  - Form an 11-bit signed candidate (cx,cy) = pos ± STEP on the selected axis only.
  - Set the out-of-range flag if cx<0, cy<0, cx+SIZE-1>639 or cy+SIZE-1>479.
  - Go to CHK with k=0.
- CHK, one corner per cycle:
  - k=0 is (cx,cy); k=1 is (cx+SIZE-1,cy); k=2 is (cx,cy+SIZE-1); k=3 is (cx+SIZE-1,cy+SIZE-1).
  - Each corner's tile is row=y>>TILE_SHIFT, col=x>>TILE_SHIFT.
  - hit |= Tile[row][col]. Skip the lookup (no out-of-bounds index) when out-of-range is set.
  - After k=3, go to DONE. There is no early exit, so latency is fixed.
- DONE, for one cycle:
  - If hit or out-of-range: position unchanged and blocked=1.
  - Otherwise pos_x/pos_y <= cx/cy.
  - move_done=1, then go to IDLE with busy=0. Clear hit and out-of-range.
- Latency:
  - frame_tick sampled at edge E0; CALC at E1; corners at E2..E5; DONE at E6.
  - The new pos_x/pos_y, move_done and blocked are visible after E6. busy is high from after E0 through E6.
- frame_tick while busy is ignored, with no queueing. dir changes after E0 have no effect on the current move.
- Tile is sampled live during CHK. The map is constant, so no latching is required.
- Reset mid-operation (any state) aborts the move: outputs return to reset values and no move_done is produced.
- A corner exactly on a tile boundary belongs to the tile on its right/below (plain shift, no rounding).

Test Plan:
- Reset, then Tile=ROM map, dir=right (0001), one frame_tick -> busy high for 6 cycles; move_done at E6, blocked=0, pos=(18,16).
- From (16,16), dir=up -> candidate y=14 hits row 0 wall -> move_done with blocked=1, pos stays (16,16). Same for dir=left (col 0 wall).
- Tile=all zeros, START_X=0, START_Y=0, dir=left -> out-of-range -> blocked=1, pos (0,0), no X/out-of-bounds index. Then dir=down -> pos (0,2).
- dir=1001 (up+right) on all-zero map from (16,16) -> up applied only, pos (16,14).
- Second frame_tick at E2 of a move -> ignored: exactly one move_done, pos advanced by one STEP only.
- Assert Reset asynchronously during CHK (between edges) -> outputs at reset values immediately, busy=0, no move_done pulse afterwards. A fresh tick then completes normally.

Source files
------------

// File: rtl/tile_collision_mover.sv
// rtl/tile_collision_mover.sv - player position register with four-corner wall collision check
module tile_collision_mover #(
    parameter int TILE_SHIFT = 4,
    parameter int SIZE       = 16,
    parameter int STEP       = 2,
    parameter int START_X    = 16,
    parameter int START_Y    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [3:0]         dir,
    input  logic [0:29][0:39]  tile,
    output logic [9:0]         pos_x,
    output logic [9:0]         pos_y,
    output logic               busy,
    output logic               move_done,
    output logic               blocked
);

    localparam logic signed [10:0] SZM1 = 11'(SIZE - 1);
    localparam logic signed [10:0] STP  = 11'(STEP);
    localparam logic signed [10:0] XMAX = 11'sd639;
    localparam logic signed [10:0] YMAX = 11'sd479;

    typedef enum logic [1:0] {IDLE, CALC, CHK, DONE} state_t;

    state_t            state;
    logic [3:0]        req;
    logic signed [10:0] cx, cy;
    logic              oor;
    logic              hit;
    logic [1:0]        k;

    logic signed [10:0] px, py, nx, ny;
    logic              nx_oor;
    logic signed [10:0] corner_x, corner_y;
    logic [10:0]       tcol, trow;
    logic              tile_bit;

    assign px = $signed({1'b0, pos_x});
    assign py = $signed({1'b0, pos_y});

    // Candidate position: only the highest-priority requested direction moves
    always_comb begin
        nx = px;
        ny = py;
        if (req[3])      ny = py - STP;
        else if (req[2]) ny = py + STP;
        else if (req[1]) nx = px - STP;
        else if (req[0]) nx = px + STP;
        nx_oor = (nx < 11'sd0) || (ny < 11'sd0) || (nx + SZM1 > XMAX) || (ny + SZM1 > YMAX);
    end

    // Current corner's wall bit; suppressed when the box is off the playfield
    always_comb begin
        corner_x = k[0] ? cx + SZM1 : cx;
        corner_y = k[1] ? cy + SZM1 : cy;
        tcol     = $unsigned(corner_x) >> TILE_SHIFT;
        trow     = $unsigned(corner_y) >> TILE_SHIFT;
        tile_bit = 1'b0;
        if (!oor && trow < 11'd30 && tcol < 11'd40)
            tile_bit = tile[trow[4:0]][tcol[5:0]];
    end

    // Move FSM: latch request, form candidate, scan four corners, commit or reject
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pos_x     <= 10'(START_X);
            pos_y     <= 10'(START_Y);
            busy      <= 1'b0;
            move_done <= 1'b0;
            blocked   <= 1'b0;
            req       <= 4'd0;
            cx        <= 11'sd0;
            cy        <= 11'sd0;
            oor       <= 1'b0;
            hit       <= 1'b0;
            k         <= 2'd0;
        end else begin
            move_done <= 1'b0;
            blocked   <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick && dir != 4'd0) begin
                        req   <= dir;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    cx    <= nx;
                    cy    <= ny;
                    oor   <= nx_oor;
                    k     <= 2'd0;
                    state <= CHK;
                end
                CHK: begin
                    hit <= hit | tile_bit;
                    if (k == 2'd3) state <= DONE;
                    else           k <= k + 2'd1;
                end
                DONE: begin
                    if (hit || oor) begin
                        blocked <= 1'b1;
                    end else begin
                        pos_x <= cx[9:0];
                        pos_y <= cy[9:0];
                    end
                    move_done <= 1'b1;
                    busy      <= 1'b0;
                    hit       <= 1'b0;
                    oor       <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
